tft_overlay_sched: RTL and testbench

//  Pixel-path scheduler between the frame source (SDRAM read-out) and the TFT driver.

---
 rtl/tft_overlay_sched_pkg.sv | 28 ++
 rtl/tft_overlay_sched_bcd_tick_counter.sv | 45 ++++
 rtl/tft_overlay_sched.sv | 112 +++++++++++
 tb/tb_tft_overlay_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tft_overlay_sched_pkg.sv
// Shared constants and types for the TFT overlay scheduler.
package tft_pkg;

  // RGB565 colour constants
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hffff;
  localparam logic [15:0] RED     = 16'hf800;
  localparam logic [15:0] GREEN   = 16'h07e0;
  localparam logic [15:0] BLUE    = 16'h001f;
  localparam logic [15:0] YELLOW  = 16'hffe0;
  localparam logic [15:0] CYAN    = 16'h07ff;
  localparam logic [15:0] MAGENTA = 16'hf81f;
  localparam logic [15:0] PINK    = 16'hfe19;

  // Pixel ownership
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    THEME = 2'd1,
    DIGIT = 2'd2
  } region_t;

  // Digit ROM address fields: {digit, row, col}
  localparam int unsigned GLYPH_DIG_W  = 4;
  localparam int unsigned GLYPH_ROW_W  = 4;
  localparam int unsigned GLYPH_COL_W  = 3;
  localparam int unsigned GLYPH_ADDR_W = GLYPH_DIG_W + GLYPH_ROW_W + GLYPH_COL_W;

endpackage

// File: rtl/tft_overlay_sched_bcd_tick_counter.sv
// Prescaled two-digit BCD counter (00..99) with synchronous clear.
module bcd_tick_counter #(
  parameter int unsigned TICK_DIV = 16777216
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Prescaler: 0..TICK_DIV-1, cleared by reset or clr
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // BCD counter: units carry into tens, 99 wraps to 00
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tens  <= '0;
      units <= '0;
    end else if (tick) begin
      if (units == 4'd9) begin
        units <= '0;
        tens  <= (tens == 4'd9) ? '0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tft_overlay_sched.sv
// Pixel-path scheduler: picks theme banner, counter glyph or camera pixel,
// drives ROM addresses and realigns data_in to the 1-cycle ROM latency.
module tft_overlay_sched
  import tft_pkg::*;
#(
  parameter int unsigned THEME_X0 = 191,
  parameter int unsigned THEME_W  = 416,
  parameter int unsigned THEME_H  = 32,
  parameter int unsigned DIG_X0   = 0,
  parameter int unsigned DIG_Y0   = 65,
  parameter int unsigned GLYPH_W  = 8,
  parameter int unsigned GLYPH_H  = 16,
  parameter int unsigned TICK_DIV = 16777216,
  parameter logic [15:0] FG_COLOR = 16'h0000,
  parameter logic [15:0] BG_COLOR = 16'hfe19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [15:0] data_in,
  input  logic        overlay_en,
  input  logic        cnt_clr,
  output logic [16:0] theme_addr,
  input  logic [15:0] theme_q,
  output logic [10:0] glyph_addr,
  input  logic        glyph_q,
  output logic [15:0] vga_data,
  output logic [3:0]  digit_tens,
  output logic [3:0]  digit_units
);

  logic [31:0] h_ext;
  logic [31:0] v_ext;
  logic        in_theme;
  logic        in_digit;
  region_t     region;
  region_t     region_d1;
  logic [15:0] data_d1;
  logic [3:0]  cnt_tens;
  logic [3:0]  cnt_units;
  logic [3:0]  glyph_digit;
  logic        frame_start;

  assign h_ext       = {21'd0, hcount};
  assign v_ext       = {21'd0, vcount};
  assign frame_start = (hcount == '0) && (vcount == '0);

  bcd_tick_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .tens  (cnt_tens),
    .units (cnt_units)
  );

  // Region decode and ROM address generation for the current pixel
  always_comb begin
    in_theme = (h_ext >= THEME_X0) && (h_ext < THEME_X0 + THEME_W) &&
               (v_ext < THEME_H);
    in_digit = (h_ext >= DIG_X0) && (h_ext < DIG_X0 + 2 * GLYPH_W) &&
               (v_ext >= DIG_Y0) && (v_ext < DIG_Y0 + GLYPH_H);
    region = NONE;
    if (overlay_en) begin
      if (in_theme)      region = THEME;
      else if (in_digit) region = DIGIT;
    end
    glyph_digit = ((h_ext - DIG_X0) < GLYPH_W) ? digit_tens : digit_units;
    theme_addr  = 17'(h_ext - THEME_X0) + 17'(v_ext * THEME_W);
    // Column truncation is the mod GLYPH_W since GLYPH_W is a power of 2
    glyph_addr  = {glyph_digit, GLYPH_ROW_W'(v_ext - DIG_Y0),
                   GLYPH_COL_W'(h_ext - DIG_X0)};
  end

  // Stage 1: hold region and camera pixel while the ROMs respond
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      region_d1 <= NONE;
      data_d1   <= '0;
    end else begin
      region_d1 <= region;
      data_d1   <= data_in;
    end
  end

  // Stage 2: select the output pixel by the delayed region
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_data <= '0;
    end else begin
      unique case (region_d1)
        THEME:   vga_data <= theme_q;
        DIGIT:   vga_data <= glyph_q ? FG_COLOR : BG_COLOR;
        default: vga_data <= data_d1;
      endcase
    end
  end

  // Displayed digits follow the counter only at frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_tens  <= '0;
      digit_units <= '0;
    end else if (frame_start) begin
      digit_tens  <= cnt_tens;
      digit_units <= cnt_units;
    end
  end

endmodule

// File: tb/tb_tft_overlay_sched.sv
// Directed self-checking bench for tft_overlay_sched (TICK_DIV=4).
module tb_tft_overlay_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [15:0] data_in;
  logic        overlay_en;
  logic        cnt_clr;
  logic [16:0] theme_addr;
  logic [15:0] theme_q;
  logic [10:0] glyph_addr;
  logic        glyph_q;
  logic [15:0] vga_data;
  logic [3:0]  digit_tens;
  logic [3:0]  digit_units;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  tft_overlay_sched #(
    .TICK_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .data_in     (data_in),
    .overlay_en  (overlay_en),
    .cnt_clr     (cnt_clr),
    .theme_addr  (theme_addr),
    .theme_q     (theme_q),
    .glyph_addr  (glyph_addr),
    .glyph_q     (glyph_q),
    .vga_data    (vga_data),
    .digit_tens  (digit_tens),
    .digit_units (digit_units)
  );

  // ROM models with registered output: theme = addr ^ A5A5, glyph bit = col LSB
  always @(posedge clk) begin
    theme_q <= theme_addr[15:0] ^ 16'ha5a5;
    glyph_q <= glyph_addr[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic [15:0] d);
    hcount  = 11'(h);
    vcount  = 11'(v);
    data_in = d;
  endtask

  task automatic check_digits(input string tag, input logic [3:0] t, input logic [3:0] u);
    check({tag, "_tens"}, {28'd0, digit_tens}, {28'd0, t});
    check({tag, "_units"}, {28'd0, digit_units}, {28'd0, u});
  endtask

  task automatic clear_counter();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; overlay_en = 1'b1; cnt_clr = 1'b0;
    pix(700, 300, 16'h0000);

    // 1 Reset
    repeat (3) step();
    check("rst_vga", {16'd0, vga_data}, 32'd0);
    check_digits("rst", 4'd0, 4'd0);
    rst_n = 1'b1;

    // 2 Passthrough with exact 2-edge latency
    pix(700, 300, 16'h0000); step();
    pix(700, 300, 16'h1234); step();
    check("pass_lat1", {16'd0, vga_data}, 32'h0000);
    step();
    check("pass_lat2", {16'd0, vga_data}, 32'h1234);
    overlay_en = 1'b0;
    pix(200, 5, 16'hbeef); step(); step();
    check("ovl_off", {16'd0, vga_data}, 32'hbeef);
    overlay_en = 1'b1;

    // 3 Theme banner
    pix(191, 0, 16'h1111); #1;
    check("theme_addr0", {15'd0, theme_addr}, 32'd0);
    step(); step();
    check("theme_q0", {16'd0, vga_data}, 32'ha5a5);
    pix(606, 31, 16'h1111); #1;
    check("theme_addr_last", {15'd0, theme_addr}, 32'd13311);
    step(); step();
    check("theme_q_last", {16'd0, vga_data}, 32'h965a);
    pix(607, 0, 16'h2222); step(); step();
    check("theme_right_edge", {16'd0, vga_data}, 32'h2222);
    pix(190, 0, 16'h3333); step(); step();
    check("theme_left_edge", {16'd0, vga_data}, 32'h3333);
    pix(300, 32, 16'h4444); step(); step();
    check("theme_bottom_edge", {16'd0, vga_data}, 32'h4444);

    // 4 Glyph: bring counter to 42 and shadow it; tick at frame start shows 41 first
    pix(700, 300, 16'h0000);
    clear_counter();
    repeat (167) step();
    pix(0, 0, 16'h0000); step();
    check_digits("tick_at_frame_old", 4'd4, 4'd1);
    step();
    check_digits("shadow42", 4'd4, 4'd2);
    pix(9, 66, 16'h5555); #1;
    check("glyph_addr_units", {21'd0, glyph_addr}, 32'd265);
    step(); step();
    check("glyph_fg", {16'd0, vga_data}, 32'h0000);
    pix(10, 66, 16'h5555); #1;
    check("glyph_addr_bg", {21'd0, glyph_addr}, 32'd266);
    step(); step();
    check("glyph_bg", {16'd0, vga_data}, 32'hfe19);
    pix(1, 65, 16'h5555); #1;
    check("glyph_addr_tens", {21'd0, glyph_addr}, 32'd513);
    pix(16, 66, 16'h6666); step(); step();
    check("digit_right_edge", {16'd0, vga_data}, 32'h6666);
    pix(5, 81, 16'h7777); step(); step();
    check("digit_bottom_edge", {16'd0, vga_data}, 32'h7777);
    check_digits("shadow42_hold", 4'd4, 4'd2);

    // 5 Counter wrap 99 -> 00 and shadow update only at frame start
    pix(700, 300, 16'h0000);
    clear_counter();
    repeat (398) step();
    pix(0, 0, 16'h0000); step();
    check_digits("cnt99", 4'd9, 4'd9);
    step();
    check_digits("wrap_old", 4'd9, 4'd9);
    step();
    check_digits("wrap00", 4'd0, 4'd0);
    pix(700, 300, 16'h0000);
    repeat (8) step();
    check_digits("hold_mid_frame", 4'd0, 4'd0);
    pix(0, 1, 16'h0000); step();
    check_digits("hold_v1", 4'd0, 4'd0);
    pix(1, 0, 16'h0000); step();
    check_digits("hold_h1", 4'd0, 4'd0);
    pix(0, 0, 16'h0000); step();
    check_digits("frame_update02", 4'd0, 4'd2);

    // 6 Clear coincident with tick at count 37
    pix(700, 300, 16'h0000);
    clear_counter();
    check_digits("clr_keeps_shadow", 4'd0, 4'd2);
    repeat (151) step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    pix(0, 0, 16'h0000); step();
    check_digits("clr_at_tick", 4'd0, 4'd0);
    pix(700, 300, 16'h0000); step(); step();
    pix(0, 0, 16'h0000); step();
    check_digits("clr_pre_tick", 4'd0, 4'd0);
    step();
    check_digits("clr_first_tick", 4'd0, 4'd1);

    // Mid-frame reset: one black cycle after release, then normal flow
    pix(700, 300, 16'h5a5a); step(); step();
    check("pre_reset", {16'd0, vga_data}, 32'h5a5a);
    rst_n = 1'b0; step();
    check("midrst_vga", {16'd0, vga_data}, 32'h0000);
    check_digits("midrst", 4'd0, 4'd0);
    rst_n = 1'b1; step();
    check("midrst_black", {16'd0, vga_data}, 32'h0000);
    step();
    check("midrst_resume", {16'd0, vga_data}, 32'h5a5a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
